// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: splits one LLC line read/write into a BEATS-long memory burst
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [LINE_W-1:0] line_q;
  logic last;
  assign last = cnt == CW'(BEATS - 1);
  assign burst_o = state == WR ? line_q[cnt*BURST_W +: BURST_W] : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      resp_o <= 1'b0;
      read_o <= 1'b0;
      write_o <= 1'b0;
      line_o <= '0;
      line_q <= '0;
      address_o <= '0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: if (read_i || write_i) begin
          state <= write_i ? WR : RD;
          read_o <= !write_i;
          write_o <= write_i;
          address_o <= address_i & ~ADDR_W'(LINE_W/8 - 1);
          cnt <= '0;
          if (write_i) line_q <= line_i;
        end
        RD: if (resp_i) begin
          line_o[cnt*BURST_W +: BURST_W] <= burst_i;
          cnt <= cnt + 1'b1;
          if (last) begin
            read_o <= 1'b0;
            resp_o <= 1'b1;
            state <= DONE;
          end
        end
        WR: if (resp_i) begin
          cnt <= cnt + 1'b1;
          if (last) begin
            write_o <= 1'b0;
            resp_o <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
